// File: rtl/stch_stream_ctrl.sv
// Stream sequencer for the shared stochastic-number datapath: double-buffered
// per-channel probabilities compared against one reseedable Galois LFSR.
`timescale 1ns/1ps
module stch_stream_ctrl #(
  parameter int unsigned ND    = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned LEN_W = 16,
  parameter logic [7:0]  SEED  = 8'h01,
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_ld_valid,
  output logic             o_ld_ready,
  input  logic [CH_W-1:0]  i_ld_ch,
  input  logic [ND-1:0]    i_ld_d,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_abort,
  output logic [NCH-1:0]   o_s,
  output logic             o_s_valid,
  input  logic             i_s_ready,
  output logic             o_init_out,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {StIdle, StPrime, StRun, StFin} state_e;

  state_e                    r_state;
  state_e                    w_state_d;
  logic [7:0]                r_lfsr;
  logic [7:0]                w_lfsr_step;
  logic [LEN_W-1:0]          r_len_cnt;
  logic [NCH-1:0][ND-1:0]    r_shadow;
  logic [NCH-1:0][ND-1:0]    r_active;
  logic                      w_beat;

  assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ 8'hB8) : (r_lfsr >> 1);
  assign w_beat      = (r_state == StRun) && i_s_ready;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (i_start) w_state_d = StPrime;
      StPrime: begin
        if (i_abort)                w_state_d = StIdle;
        else if (r_len_cnt == '0)   w_state_d = StFin;
        else                        w_state_d = StRun;
      end
      StRun: begin
        // Abort wins over the last-beat move to FIN.
        if (i_abort)                                   w_state_d = StIdle;
        else if (i_s_ready && r_len_cnt == LEN_W'(1))  w_state_d = StFin;
      end
      StFin:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_lfsr    <= SEED;
      r_len_cnt <= '0;
      r_shadow  <= '0;
      r_active  <= '0;
    end else begin
      r_state <= w_state_d;
      if (r_state == StIdle && i_start) r_len_cnt <= i_len;
      if (r_state == StPrime) begin
        r_lfsr   <= SEED;
        r_active <= r_shadow;
      end
      if (w_beat) begin
        r_lfsr    <= w_lfsr_step;
        r_len_cnt <= r_len_cnt - LEN_W'(1);
      end
      if (i_ld_valid && o_ld_ready) r_shadow[i_ld_ch] <= i_ld_d;
    end
  end

  assign o_s_valid  = (r_state == StRun);
  assign o_init_out = (r_state == StPrime);
  assign o_ld_ready = (r_state != StPrime);
  assign o_busy     = (r_state != StIdle);
  assign o_done     = (r_state == StFin);

  // Full-scale probability saturates to always-one, since the LFSR never emits 0.
  always_comb begin
    o_s = '0;
    for (int i = 0; i < NCH; i++) begin
      o_s[i] = o_s_valid & ((r_active[i] > r_lfsr) | (r_active[i] == {ND{1'b1}}));
    end
  end

endmodule

// File: tb/tb_stch_stream_ctrl.sv
// Self-checking bench for stch_stream_ctrl: directed scenarios plus randomized
// streams compared against a spec-level model (LFSR sequence table, shadow/active copies).
`timescale 1ns/1ps
module tb_stch_stream_ctrl;

  localparam logic [7:0] SEED = 8'h01;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [1:0]  ld_ch = '0;
  logic [7:0]  ld_d = '0;
  logic        start = 1'b0;
  logic [15:0] len = '0;
  logic        abort = 1'b0;
  logic [3:0]  s;
  logic        s_valid;
  logic        s_ready = 1'b1;
  logic        init_out;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [7:0]  seq [255];
  logic [7:0]  sh [4];
  int          ones [4];
  logic [31:0] ch0bits;
  int          done_cyc;

  always #5 clk = ~clk;

  stch_stream_ctrl #(.ND(8), .NCH(4), .LEN_W(16), .SEED(SEED)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ld_valid(ld_valid), .o_ld_ready(ld_ready),
    .i_ld_ch(ld_ch), .i_ld_d(ld_d), .i_start(start), .i_len(len), .i_abort(abort),
    .o_s(s), .o_s_valid(s_valid), .i_s_ready(s_ready), .o_init_out(init_out),
    .o_busy(busy), .o_done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input logic [7:0] d);
    chk("load_ready_idle", ld_ready, 1);
    ld_valid = 1'b1; ld_ch = 2'(ch); ld_d = d;
    tick();
    ld_valid = 1'b0;
    sh[ch] = d;
  endtask

  // mode: 0 no stall, 1 random stall, 2 stall 3 cycles on 2nd beat, 3 load ch0=FF on 2nd beat
  task automatic run_stream(input int n, input int mode, input int abort_at, input bit rnd);
    logic [7:0] act [4];
    logic [3:0] exp_s;
    logic [7:0] v;
    int  k, cyc, stalled, guard;
    bit  aborted, acc, rdy;
    done_cyc = -1; ch0bits = '0;
    foreach (ones[i]) ones[i] = 0;
    len = 16'(n); start = 1'b1;
    acc = 1'b0;
    if (rnd && $urandom_range(0, 1) == 1) begin
      ld_valid = 1'b1; ld_ch = 2'($urandom_range(0, 3)); ld_d = 8'($urandom); acc = 1'b1;
    end
    tick();
    if (acc) sh[ld_ch] = ld_d;
    start = 1'b0; ld_valid = 1'b0; cyc = 1;
    chk("prime_init", init_out, 1);
    chk("prime_busy", busy, 1);
    chk("prime_ld_ready", ld_ready, 0);
    chk("prime_s_valid", s_valid, 0);
    chk("prime_s", s, 0);
    chk("prime_done", done, 0);
    foreach (act[i]) act[i] = sh[i];
    // A load offered during PRIME must be refused.
    if (rnd) begin ld_valid = 1'b1; ld_ch = 2'($urandom_range(0, 3)); ld_d = 8'($urandom); end
    tick();
    ld_valid = 1'b0; cyc = 2;
    k = 0; stalled = 0; guard = 0; aborted = 1'b0;
    while (k < n && !aborted && guard < 4 * n + 20) begin
      guard++;
      v = seq[k % 255];
      for (int i = 0; i < 4; i++) exp_s[i] = (act[i] > v) || (act[i] == 8'hFF);
      chk("run_s_valid", s_valid, 1);
      chk("run_s", s, exp_s);
      chk("run_init", init_out, 0);
      chk("run_done", done, 0);
      chk("run_busy", busy, 1);
      if (mode == 1)                         rdy = ($urandom_range(0, 3) != 0);
      else if (mode == 2 && k == 1 && stalled < 3) begin rdy = 1'b0; stalled++; end
      else                                   rdy = 1'b1;
      s_ready = rdy;
      if (k == abort_at && rdy) abort = 1'b1;
      acc = 1'b0;
      if (mode == 3 && k == 1 && rdy) begin
        ld_valid = 1'b1; ld_ch = 2'd0; ld_d = 8'hFF; acc = 1'b1;
      end else if (rnd && $urandom_range(0, 2) == 0) begin
        ld_valid = 1'b1; ld_ch = 2'($urandom_range(0, 3)); ld_d = 8'($urandom); acc = 1'b1;
      end
      if (rnd) start = 1'($urandom_range(0, 1));
      if (rdy) begin
        for (int i = 0; i < 4; i++) ones[i] += int'(s[i]);
        ch0bits = {ch0bits[30:0], s[0]};
      end
      tick();
      cyc++;
      if (acc) sh[ld_ch] = ld_d;
      ld_valid = 1'b0;
      if (abort) aborted = 1'b1;
      abort = 1'b0;
      if (rdy) k++;
    end
    start = 1'b0; s_ready = 1'b1;
    if (guard >= 4 * n + 20) chk("run_guard_expired", 1, 0);
    if (aborted) begin
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_s_valid", s_valid, 0);
      tick();
      chk("abort_no_done_later", done, 0);
    end else begin
      chk("fin_done", done, 1);
      chk("fin_busy", busy, 1);
      chk("fin_s_valid", s_valid, 0);
      chk("fin_init", init_out, 0);
      done_cyc = cyc;
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_ld_ready", ld_ready, 1);
      tick();
      chk("start_not_queued", busy, 0);
    end
  endtask

  initial begin
    seq[0] = SEED;
    for (int i = 1; i < 255; i++)
      seq[i] = seq[i-1][0] ? ((seq[i-1] >> 1) ^ 8'hB8) : (seq[i-1] >> 1);
    foreach (sh[i]) sh[i] = 8'h00;

    #1;
    chk("rst_s", s, 0);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_init", init_out, 0);
    chk("rst_ld_ready", ld_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic stream
    load(0, 8'h80);
    run_stream(4, 0, -1, 1'b0);
    chk("basic_done_cyc", done_cyc, 6);
    chk("basic_bits", ch0bits[3:0], 4'b1011);

    // Back-pressure: three stalls on the second beat
    run_stream(4, 2, -1, 1'b0);
    chk("bp_done_cyc", done_cyc, 9);
    chk("bp_bits", ch0bits[3:0], 4'b1011);

    // Density over a full LFSR period
    load(1, 8'hFF); load(2, 8'h00); load(3, 8'h01);
    run_stream(255, 0, -1, 1'b0);
    chk("dens_ch0", ones[0], 127);
    chk("dens_ch1", ones[1], 255);
    chk("dens_ch2", ones[2], 0);
    chk("dens_ch3", ones[3], 0);

    // Double buffer
    load(0, 8'h00);
    run_stream(6, 3, -1, 1'b0);
    chk("dbuf_cur", ones[0], 0);
    run_stream(6, 0, -1, 1'b0);
    chk("dbuf_next", ones[0], 6);

    // Zero length
    run_stream(0, 0, -1, 1'b0);
    chk("len0_done_cyc", done_cyc, 2);

    // Abort on final beat, and early abort with random traffic
    run_stream(5, 0, 4, 1'b0);
    run_stream(10, 1, 3, 1'b1);

    // Randomized streams, one long enough to wrap the LFSR
    for (int r = 0; r < 12; r++) begin
      int n;
      n = $urandom_range(0, 40);
      run_stream(n, 1, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 40)) : -1, 1'b1);
    end
    run_stream(300, 1, -1, 1'b1);
    chk("wrap_done", done_cyc >= 302, 1);

    // Asynchronous reset mid-run
    len = 16'd20; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("pre_rst_s_valid", s_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_s", s, 0);
    chk("arst_s_valid", s_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_init", init_out, 0);
    chk("arst_ld_ready", ld_ready, 1);
    tick();
    rst_n = 1'b1;
    foreach (sh[i]) sh[i] = 8'h00;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    run_stream(3, 0, -1, 1'b0);
    chk("post_rst_ones", ones[0] + ones[1] + ones[2] + ones[3], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
